// File: rtl/arbitro_sumador.sv
// -----------------------------------------------------------------------------
// arbitro_sumador
//
// Round-robin arbiter and sequencer that time-shares one external W-bit adder
// between NREQ requesters. A winning requester's operand pair is registered,
// driven to the shared adder, and the sum is captured one cycle later and
// returned to that requester through a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   req_valid   [NREQ]    per-requester operation request
//   req_a       [NREQ*W]  operand A, requester i at [i*W +: W]
//   req_b       [NREQ*W]  operand B, same packing
//   req_ready   [NREQ]    one-hot grant (only in IDLE, combinational)
//   resp_valid  [NREQ]    one-hot result-valid for the owning requester
//   resp_ready  [NREQ]    per-requester result acceptance
//   resp_data   [W]       registered sum
//   sum_a/sum_b [W]       registered operands to the shared adder
//   sum_result  [W]       shared adder output (combinational in sum_a/sum_b)
//   busy                  high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module arbitro_sumador #(
   parameter int NREQ = 4,
   parameter int W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [W-1:0]      resp_data,
   output logic [W-1:0]      sum_a,
   output logic [W-1:0]      sum_b,
   input  logic [W-1:0]      sum_result,
   output logic              busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [PW-1:0] ptr_reg, ptr_next;
   logic [PW-1:0] owner_reg, owner_next;
   logic [W-1:0]  op_a_reg, op_a_next;
   logic [W-1:0]  op_b_reg, op_b_next;
   logic [W-1:0]  resp_data_reg, resp_data_next;

   // Unpacked views of the packed operand buses.
   logic [W-1:0] a_arr [NREQ];
   logic [W-1:0] b_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[gi*W +: W];
         assign b_arr[gi] = req_b[gi*W +: W];
      end
   endgenerate

   // Rotating priority search starting at ptr. Candidates are visited from
   // lowest to highest priority so the last hit (closest to ptr) wins,
   // which avoids an early exit from the loop.
   logic [PW-1:0] win_idx;
   logic          win_found;
   int            cand;

   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = int'(ptr_reg) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (req_valid[cand]) begin
            win_idx   = PW'(cand);
            win_found = 1'b1;
         end
      end
   end

   // Grant and result-valid decode, one bit per requester.
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_decode
         assign req_ready[gi]  = (state_reg == IDLE) && win_found && (win_idx == PW'(gi));
         assign resp_valid[gi] = (state_reg == RESP) && (owner_reg == PW'(gi));
      end
   endgenerate

   // Next-state and register-update logic.
   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      owner_next     = owner_reg;
      op_a_next      = op_a_reg;
      op_b_next      = op_b_reg;
      resp_data_next = resp_data_reg;
      case (state_reg)
         IDLE: begin
            if (win_found) begin
               op_a_next  = a_arr[win_idx];
               op_b_next  = b_arr[win_idx];
               owner_next = win_idx;
               // Priority moves just past the winner so it cannot starve others.
               ptr_next   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            // Adder output settles from the operand registers within this cycle.
            resp_data_next = sum_result;
            state_next     = RESP;
         end
         RESP: begin
            // Only the owner's acceptance completes the operation.
            if (resp_ready[owner_reg]) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         owner_reg     <= '0;
         op_a_reg      <= '0;
         op_b_reg      <= '0;
         resp_data_reg <= '0;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         owner_reg     <= owner_next;
         op_a_reg      <= op_a_next;
         op_b_reg      <= op_b_next;
         resp_data_reg <= resp_data_next;
      end
   end

   assign sum_a     = op_a_reg;
   assign sum_b     = op_b_reg;
   assign resp_data = resp_data_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_arbitro_sumador.sv
// -----------------------------------------------------------------------------
// tb_arbitro_sumador
//
// Self-checking bench for arbitro_sumador (NREQ=4, W=32). The external shared
// adder is modelled by a continuous sum_a+sum_b. Expected grants come from a
// rotation-order model (first valid requester at ptr, ptr+1, ... mod 4) and
// expected results from plain 32-bit addition of the bench's own operands.
// -----------------------------------------------------------------------------
module tb_arbitro_sumador;

   localparam int NREQ = 4;
   localparam int W    = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   resp_valid;
   logic [NREQ-1:0]   resp_ready;
   logic [W-1:0]      resp_data;
   logic [W-1:0]      sum_a;
   logic [W-1:0]      sum_b;
   logic [W-1:0]      sum_result;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;
   logic [W-1:0] ta [NREQ];
   logic [W-1:0] tb [NREQ];

   always #5 clk = ~clk;

   // External shared adder.
   assign sum_result = sum_a + sum_b;

   arbitro_sumador #(.NREQ(NREQ), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .sum_a      (sum_a),
      .sum_b      (sum_b),
      .sum_result (sum_result),
      .busy       (busy)
   );

   // Winner = first requester with valid set, scanning ptr, ptr+1, ... mod NREQ.
   function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 4))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'h0000_0001;
         default: return $urandom();
      endcase
   endfunction

   task automatic set_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*W +: W] = ta[i];
         req_b[i*W +: W] = tb[i];
      end
   endtask

   task automatic randomize_ops();
      for (int i = 0; i < NREQ; i++) begin
         ta[i] = rand_op();
         tb[i] = rand_op();
      end
      set_ops();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      #2 rst = 1'b0;
      model_ptr = 0;
      @(negedge clk);
   endtask

   // Drives one operation from an IDLE negedge with full response acceptance
   // and records what the DUT showed at each phase. Returns at the next IDLE
   // negedge with req_valid still driven to vmask.
   task automatic run_op(input logic [NREQ-1:0] vmask,
                         output logic [NREQ-1:0] g,
                         output logic [W-1:0] sa, output logic [W-1:0] sb,
                         output logic [NREQ-1:0] rv_calc,
                         output logic [NREQ-1:0] rv,
                         output logic [W-1:0] rd,
                         output int bcnt);
      req_valid  = vmask;
      resp_ready = '1;
      #1 g = req_ready;
      bcnt = 0;
      @(negedge clk);
      sa = sum_a; sb = sum_b; rv_calc = resp_valid; bcnt += int'(busy);
      @(negedge clk);
      rv = resp_valid; rd = resp_data; bcnt += int'(busy);
      @(negedge clk);
      bcnt += int'(busy);
      $display("op req=%b grant=%b a=%h b=%h resp_valid=%b data=%h", vmask, g, sa, sb, rv, rd);
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 4'b0)  begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (sum_a !== 32'h0)     begin errors++; $display("FAIL reset_sum_a: got %h expected 0", sum_a); end
      checks++; if (sum_b !== 32'h0)     begin errors++; $display("FAIL reset_sum_b: got %h expected 0", sum_b); end
      checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
      rst = 1'b0;
      model_ptr = 0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [NREQ-1:0] g, rvc, rv;
      logic [W-1:0] sa, sb, rd;
      int bc, w;
      ta[2] = 32'd5; tb[2] = 32'd7; set_ops();
      w = model_pick(4'b0100, model_ptr);
      run_op(4'b0100, g, sa, sb, rvc, rv, rd, bc);
      req_valid = '0;
      model_ptr = (w + 1) % NREQ;
      checks++; if (g !== 4'(1 << w))  begin errors++; $display("FAIL single_grant: got %b expected %b", g, 4'(1 << w)); end
      checks++; if (sa !== 32'd5)      begin errors++; $display("FAIL single_sum_a: got %h expected 5", sa); end
      checks++; if (sb !== 32'd7)      begin errors++; $display("FAIL single_sum_b: got %h expected 7", sb); end
      checks++; if (rvc !== 4'b0)      begin errors++; $display("FAIL single_early_valid: got %b expected 0000", rvc); end
      checks++; if (rv !== 4'b0100)    begin errors++; $display("FAIL single_resp_valid: got %b expected 0100", rv); end
      checks++; if (rd !== ta[2] + tb[2]) begin errors++; $display("FAIL single_resp_data: got %0d expected %0d", rd, ta[2] + tb[2]); end
      checks++; if (bc != 2)           begin errors++; $display("FAIL single_busy_cycles: got %0d expected 2", bc); end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] g, rvc, rv;
      logic [W-1:0] sa, sb, rd, e;
      int bc, w;
      pulse_reset();
      for (int i = 0; i < NREQ; i++) begin
         ta[i] = $urandom(); tb[i] = 32'(i * 1000 + 17);
      end
      set_ops();
      for (int n = 0; n < 5; n++) begin
         w = model_pick(4'hF, model_ptr);
         run_op(4'hF, g, sa, sb, rvc, rv, rd, bc);
         model_ptr = (w + 1) % NREQ;
         e = ta[w] + tb[w];
         checks++; if (g !== 4'(1 << w))  begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", n, g, 4'(1 << w)); end
         checks++; if (rv !== 4'(1 << w)) begin errors++; $display("FAIL rr_resp_valid[%0d]: got %b expected %b", n, rv, 4'(1 << w)); end
         checks++; if (rd !== e)          begin errors++; $display("FAIL rr_resp_data[%0d]: got %h expected %h", n, rd, e); end
      end
      req_valid = '0;
   endtask

   task automatic test_wrap();
      logic [NREQ-1:0] g, rvc, rv;
      logic [W-1:0] sa, sb, rd, e;
      int bc, w, r;
      for (int n = 0; n < 2; n++) begin
         r = $urandom_range(0, NREQ - 1);
         ta[r] = (n == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
         tb[r] = (n == 0) ? 32'h0000_0001 : 32'h8000_0000;
         set_ops();
         w = model_pick(4'(1 << r), model_ptr);
         run_op(4'(1 << r), g, sa, sb, rvc, rv, rd, bc);
         req_valid = '0;
         model_ptr = (w + 1) % NREQ;
         e = ta[r] + tb[r];
         checks++; if (rv !== 4'(1 << r)) begin errors++; $display("FAIL wrap_resp_valid[%0d]: got %b expected %b", n, rv, 4'(1 << r)); end
         checks++; if (rd !== e)          begin errors++; $display("FAIL wrap_resp_data[%0d]: got %h expected %h", n, rd, e); end
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] g, rvc, rv, v;
      logic [W-1:0] sa, sb, rd, e;
      int bc, w;
      for (int n = 0; n < 40; n++) begin
         v = 4'($urandom_range(0, 15));
         randomize_ops();
         if (v == 4'b0) begin
            req_valid = '0;
            #1;
            checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rand_idle_grant[%0d]: got %b expected 0000", n, req_ready); end
            @(negedge clk);
            checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rand_idle_busy[%0d]: got %b expected 0", n, busy); end
         end else begin
            w = model_pick(v, model_ptr);
            run_op(v, g, sa, sb, rvc, rv, rd, bc);
            model_ptr = (w + 1) % NREQ;
            e = ta[w] + tb[w];
            checks++; if (g !== 4'(1 << w))  begin errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", n, g, 4'(1 << w)); end
            checks++; if (sa !== ta[w] || sb !== tb[w]) begin errors++; $display("FAIL rand_operands[%0d]: got %h,%h expected %h,%h", n, sa, sb, ta[w], tb[w]); end
            checks++; if (rv !== 4'(1 << w)) begin errors++; $display("FAIL rand_resp_valid[%0d]: got %b expected %b", n, rv, 4'(1 << w)); end
            checks++; if (rd !== e)          begin errors++; $display("FAIL rand_resp_data[%0d]: got %h expected %h", n, rd, e); end
            checks++; if (bc != 2)           begin errors++; $display("FAIL rand_busy_cycles[%0d]: got %0d expected 2", n, bc); end
         end
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] e;
      randomize_ops();
      e = ta[1] + tb[1];
      req_valid = 4'b0010; resp_ready = '0;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", req_ready); end
      @(negedge clk);
      req_valid = 4'b1101; resp_ready = 4'b1101;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL bp_resp_valid[%0d]: got %b expected 0010", c, resp_valid); end
         checks++; if (resp_data !== e)        begin errors++; $display("FAIL bp_resp_data[%0d]: got %h expected %h", c, resp_data, e); end
         checks++; if (req_ready !== 4'b0)     begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0000", c, req_ready); end
         checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", c, busy); end
      end
      req_valid = '0; resp_ready = 4'b0010;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || resp_valid !== 4'b0) begin errors++; $display("FAIL bp_complete: got busy=%b resp_valid=%b expected 0/0000", busy, resp_valid); end
      $display("op req=0010 backpressured data=%h", e);
      resp_ready = '0;
      model_ptr = 2;
   endtask

   task automatic test_midreset();
      logic [NREQ-1:0] g, rvc, rv;
      logic [W-1:0] sa, sb, rd, e;
      int bc, w;
      randomize_ops();
      // Reset while in CALC.
      req_valid = 4'b0100; resp_ready = '0;
      @(negedge clk);
      req_valid = '0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_calc_busy: got %b expected 1", busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || sum_a !== 32'h0 || sum_b !== 32'h0) begin errors++; $display("FAIL mr_calc_reset: got busy=%b sum_a=%h sum_b=%h expected 0/0/0", busy, sum_a, sum_b); end
      #1 rst = 1'b0;
      model_ptr = 0;
      @(negedge clk);
      // Reset while in RESP.
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL mr_resp_valid: got %b expected 0100", resp_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (resp_valid !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL mr_resp_reset: got resp_valid=%b busy=%b expected 0000/0", resp_valid, busy); end
      checks++; if (resp_data !== 32'h0 || sum_a !== 32'h0) begin errors++; $display("FAIL mr_resp_regs: got resp_data=%h sum_a=%h expected 0/0", resp_data, sum_a); end
      #1 rst = 1'b0;
      model_ptr = 0;
      @(negedge clk);
      // Requesters 1 and 3 compete after reset: pointer is back at 0.
      req_valid = 4'b1010;
      #1;
      w = model_pick(4'b1010, model_ptr);
      checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL mr_first_grant: got %b expected %b", req_ready, 4'(1 << w)); end
      for (int n = 0; n < 2; n++) begin
         w = model_pick(4'b1010, model_ptr);
         run_op(4'b1010, g, sa, sb, rvc, rv, rd, bc);
         model_ptr = (w + 1) % NREQ;
         e = ta[w] + tb[w];
         checks++; if (g !== 4'(1 << w)) begin errors++; $display("FAIL mr_grant[%0d]: got %b expected %b", n, g, 4'(1 << w)); end
         checks++; if (rd !== e)         begin errors++; $display("FAIL mr_resp_data[%0d]: got %h expected %h", n, rd, e); end
      end
      req_valid = '0;
   endtask

   task automatic test_fairness();
      logic [NREQ-1:0] g, rvc, rv;
      logic [W-1:0] sa, sb, rd, e;
      int bc, w;
      pulse_reset();
      randomize_ops();
      req_valid = 4'b0001; resp_ready = '1;
      #1;
      w = model_pick(4'b0001, model_ptr);
      checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL fair_first_grant: got %b expected %b", req_ready, 4'(1 << w)); end
      model_ptr = (w + 1) % NREQ;
      @(negedge clk);
      req_valid = 4'b1001;     // requester 3 arrives while 0 is being served
      @(negedge clk);
      @(negedge clk);
      #1;
      w = model_pick(4'b1001, model_ptr);
      checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL fair_next_grant: got %b expected %b", req_ready, 4'(1 << w)); end
      run_op(4'b1001, g, sa, sb, rvc, rv, rd, bc);
      model_ptr = (w + 1) % NREQ;
      e = ta[w] + tb[w];
      checks++; if (rd !== e) begin errors++; $display("FAIL fair_resp_data: got %h expected %h", rd, e); end
      w = model_pick(4'b0001, model_ptr);
      run_op(4'b0001, g, sa, sb, rvc, rv, rd, bc);
      model_ptr = (w + 1) % NREQ;
      checks++; if (g !== 4'(1 << w)) begin errors++; $display("FAIL fair_return_grant: got %b expected %b", g, 4'(1 << w)); end
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_random();
      test_backpressure();
      test_midreset();
      test_fairness();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
